reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement queue between issue/execute and regFile. Allocates a tag per issued
//  instruction, collects results from the CDB, commits one instruction per cycle in
//  program order to regFile (ROB_* inputs), and raises rollback on a mispredicted branch.
//  Tag 0 is reserved for "no dependency"; entry i has tag i+1.
// PARAMETERS
//  ROB_SIZE  16  Number of entries; must be <= 2**`ROBWidth - 1 (tag 0 reserved).
// PORTS
//  clk               in   1            clock; all state changes on posedge
//  rst               in   1            synchronous reset, active-high
//  rdy               in   1            global enable; low = hold all state
//  issue_valid       in   1            IQ issues an instruction this cycle
//  issue_rd          in   `RegWidth    destination register (0 = none / branch)
//  issue_is_branch   in   1            instruction is a branch/jump
//  issue_pred_pc     in   32           predicted next PC (branches only)
//  alloc_tag         out  `ROBWidth    tag given to the issuing instruction (tail+1)
//  full              out  1            no free entry; issue ignored
//  cdb_valid         in   1            execute unit broadcasts a result
//  cdb_tag           in   `ROBWidth    tag of the producing entry
//  cdb_val           in   32           result value
//  cdb_real_pc       in   32           resolved next PC (branches only)
//  commit_valid      out  1            to regFile ROB_valid
//  commit_rd         out  `RegWidth    to regFile ROB_rd
//  commit_tag        out  `ROBWidth    to regFile ROB_rdTag
//  commit_val        out  32           to regFile ROB_rdVal
//  rollback          out  1            mispredict flush pulse (regFile, IQ, fetch)
//  rollback_pc       out  32           correct fetch PC when rollback=1
//  stat_commits      out  32           committed-instruction count (ROB_STATS_EN)
//  stat_rollbacks    out  32           rollback count (ROB_STATS_EN)
// BEHAVIOUR
//  - Per entry: busy, ready, is_branch, rd, val, pred_pc, real_pc. head, tail, count regs.
//  - Reset: head=tail=count=0, all busy/ready=0; commit_valid=0, commit_rd=0, commit_tag=0,
//    commit_val=0, rollback=0, rollback_pc=0, stats=0. Reset mid-operation discards all entries.
//  - rdy=0: no state change; commit_valid and rollback forced 0 next edge.
//  - full = (count == ROB_SIZE), from registered count. alloc_tag = tail+1, combinational.
//  - Issue: issue_valid && !full && !rollback -> entry[tail] busy=1, ready=0, fields latched;
//    tail wraps ROB_SIZE-1 -> 0. Issue while full, or while rollback=1, is dropped.
//  - CDB: cdb_valid && cdb_tag!=0 && entry[cdb_tag-1].busy -> ready=1, val, real_pc latched.
//    Writes to tag 0 or a non-busy entry are ignored.
//  - Commit (registered, 1/cycle): if entry[head].busy && ready: commit_valid=1, commit_rd=rd
//    (0 for branches), commit_tag=head+1, commit_val=val; entry freed, head wraps. Else commit_valid=0.
//  - Latency: CDB in cycle c -> commit_valid visible in cycle c+2 if entry is head.
//  - Simultaneous issue + commit: count unchanged; legal even when count==ROB_SIZE-1.
//    When full, issue rejected even if a commit happens the same edge.
//  - Mispredict: committing branch with real_pc != pred_pc -> same edge: commit outputs as
//    above, rollback=1, rollback_pc=real_pc, head=tail=count=0, all busy/ready cleared;
//    same-edge issue and CDB writes discarded. rollback is a single-cycle pulse.
//  - Correct branch: commit only, rollback stays 0.
// CONFIGURATION
//  ROB_STATS_EN defined: stat_commits += 1 per commit, stat_rollbacks += 1 per rollback,
//    both wrap at 2**32, cleared by rst, held when rdy=0.
//  ROB_STATS_EN undefined: counters not built, stat_* tied to 0; all else identical.
// TESTING
//  1. rst, then issue rd=5 -> alloc_tag=1; CDB tag=1 val=0xDEAD -> 2 cycles later
//     commit_valid=1, rd=5, tag=1, val=0xDEAD for exactly one cycle.
//  2. Issue 16 without CDB -> full=1; 17th issue dropped, tail unchanged; one commit -> full=0.
//  3. Out-of-order CDB: issue tags 1,2,3; CDB 3,2,1 -> commits in order 1,2,3, one per cycle.
//  4. Branch pred_pc=0x100, CDB real_pc=0x200 -> rollback=1, rollback_pc=0x200, count=0,
//     next alloc_tag=1; issue in rollback cycle ignored.
//  5. Wrap: 40 issue/commit pairs -> tags cycle 1..16..1, no loss; CDB to tag 0 no effect.
//  6. rdy=0 for 3 cycles with ready head -> no commit; rst mid-run -> all outputs 0.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags at issue, collects CDB results, commits one
// entry per cycle and flushes on a mispredicted branch. Optional ROB_STATS_EN adds counters.
`ifndef RegWidth
`define RegWidth 5
`endif
`ifndef ROBWidth
`define ROBWidth 5
`endif

module reorder_buffer #(
  parameter int ROB_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue_valid,
  input  logic [`RegWidth-1:0] issue_rd,
  input  logic                 issue_is_branch,
  input  logic [31:0]          issue_pred_pc,
  output logic [`ROBWidth-1:0] alloc_tag,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [`ROBWidth-1:0] cdb_tag,
  input  logic [31:0]          cdb_val,
  input  logic [31:0]          cdb_real_pc,
  output logic                 commit_valid,
  output logic [`RegWidth-1:0] commit_rd,
  output logic [`ROBWidth-1:0] commit_tag,
  output logic [31:0]          commit_val,
  output logic                 rollback,
  output logic [31:0]          rollback_pc,
  output logic [31:0]          stat_commits,
  output logic [31:0]          stat_rollbacks
);
  localparam int IW = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam int CW = $clog2(ROB_SIZE + 1);
  localparam int TW = `ROBWidth;
  localparam int RW = `RegWidth;

  typedef struct packed {
    logic          busy;
    logic          ready;
    logic          is_branch;
    logic [RW-1:0] rd;
    logic [31:0]   val;
    logic [31:0]   pred_pc;
    logic [31:0]   real_pc;
  } rob_entry_t;

  rob_entry_t [ROB_SIZE-1:0] ent_q, ent_d;
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          commit_valid_q, commit_valid_d;
  logic [RW-1:0] commit_rd_q, commit_rd_d;
  logic [TW-1:0] commit_tag_q, commit_tag_d;
  logic [31:0]   commit_val_q, commit_val_d;
  logic          rollback_q, rollback_d;
  logic [31:0]   rollback_pc_q, rollback_pc_d;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    return (p == IW'(ROB_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  rob_entry_t    head_ent;
  logic [IW-1:0] cdb_idx;
  logic          do_commit, mispredict, do_issue, do_cdb;

  assign head_ent   = ent_q[head_q];
  assign cdb_idx    = IW'(cdb_tag - 1'b1);
  assign full       = (count_q == CW'(ROB_SIZE));
  assign alloc_tag  = TW'(tail_q) + 1'b1;
  assign do_commit  = rdy && head_ent.busy && head_ent.ready;
  assign mispredict = do_commit && head_ent.is_branch && (head_ent.real_pc != head_ent.pred_pc);
  // rollback_q blocks issue in the pulse cycle: fetch is still delivering wrong-path work
  assign do_issue   = rdy && issue_valid && !full && !rollback_q;
  assign do_cdb     = rdy && cdb_valid && (cdb_tag != '0) && (cdb_tag <= TW'(ROB_SIZE))
                      && ent_q[cdb_idx].busy;

  always_comb begin
    ent_d          = ent_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_tag_d   = commit_tag_q;
    commit_val_d   = commit_val_q;
    rollback_d     = 1'b0;
    rollback_pc_d  = rollback_pc_q;
    if (do_commit) begin
      commit_valid_d = 1'b1;
      commit_rd_d    = head_ent.is_branch ? '0 : head_ent.rd;
      commit_tag_d   = TW'(head_q) + 1'b1;
      commit_val_d   = head_ent.val;
    end
    if (mispredict) begin
      // Flush everything younger; same-edge issue/CDB traffic is wrong-path
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_d[i].busy  = 1'b0;
        ent_d[i].ready = 1'b0;
      end
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      rollback_d    = 1'b1;
      rollback_pc_d = head_ent.real_pc;
    end else begin
      if (do_cdb) begin
        ent_d[cdb_idx].ready   = 1'b1;
        ent_d[cdb_idx].val     = cdb_val;
        ent_d[cdb_idx].real_pc = cdb_real_pc;
      end
      if (do_commit) begin
        ent_d[head_q].busy  = 1'b0;
        ent_d[head_q].ready = 1'b0;
        head_d              = wrap_inc(head_q);
      end
      if (do_issue) begin
        ent_d[tail_q].busy      = 1'b1;
        ent_d[tail_q].ready     = 1'b0;
        ent_d[tail_q].is_branch = issue_is_branch;
        ent_d[tail_q].rd        = issue_rd;
        ent_d[tail_q].pred_pc   = issue_pred_pc;
        tail_d                  = wrap_inc(tail_q);
      end
      count_d = count_q + CW'(do_issue) - CW'(do_commit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_tag_q   <= '0;
      commit_val_q   <= '0;
      rollback_q     <= 1'b0;
      rollback_pc_q  <= '0;
    end else begin
      ent_q          <= ent_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_tag_q   <= commit_tag_d;
      commit_val_q   <= commit_val_d;
      rollback_q     <= rollback_d;
      rollback_pc_q  <= rollback_pc_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_tag   = commit_tag_q;
  assign commit_val   = commit_val_q;
  assign rollback     = rollback_q;
  assign rollback_pc  = rollback_pc_q;

`ifdef ROB_STATS_EN
  logic [31:0] stat_commits_q, stat_commits_d, stat_rollbacks_q, stat_rollbacks_d;

  always_comb begin
    stat_commits_d   = stat_commits_q + 32'(do_commit);
    stat_rollbacks_d = stat_rollbacks_q + 32'(mispredict);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_commits_q   <= '0;
      stat_rollbacks_q <= '0;
    end else begin
      stat_commits_q   <= stat_commits_d;
      stat_rollbacks_q <= stat_rollbacks_d;
    end
  end

  assign stat_commits   = stat_commits_q;
  assign stat_rollbacks = stat_rollbacks_q;
`else
  assign stat_commits   = '0;
  assign stat_rollbacks = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, full, out-of-order CDB, rollback, wrap, rdy/rst.
`ifndef RegWidth
`define RegWidth 5
`endif
`ifndef ROBWidth
`define ROBWidth 5
`endif

module tb_reorder_buffer;
`ifdef ROB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst, rdy;
  logic                 issue_valid, issue_is_branch;
  logic [`RegWidth-1:0] issue_rd;
  logic [31:0]          issue_pred_pc;
  logic [`ROBWidth-1:0] alloc_tag;
  logic                 full;
  logic                 cdb_valid;
  logic [`ROBWidth-1:0] cdb_tag;
  logic [31:0]          cdb_val, cdb_real_pc;
  logic                 commit_valid;
  logic [`RegWidth-1:0] commit_rd;
  logic [`ROBWidth-1:0] commit_tag;
  logic [31:0]          commit_val;
  logic                 rollback;
  logic [31:0]          rollback_pc, stat_commits, stat_rollbacks;

  int n_chk = 0;
  int n_err = 0;

  reorder_buffer #(.ROB_SIZE(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
    .issue_pred_pc(issue_pred_pc), .alloc_tag(alloc_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_real_pc(cdb_real_pc),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_val(commit_val), .rollback(rollback), .rollback_pc(rollback_pc),
    .stat_commits(stat_commits), .stat_rollbacks(stat_rollbacks)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic br, input logic [31:0] pc);
    issue_valid = 1'b1; issue_rd = rd; issue_is_branch = br; issue_pred_pc = pc;
    cyc();
    issue_valid = 1'b0; issue_is_branch = 1'b0;
  endtask

  task automatic do_cdb(input logic [4:0] tag, input logic [31:0] val, input logic [31:0] rpc);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_val = val; cdb_real_pc = rpc;
    cyc();
    cdb_valid = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0; issue_pred_pc = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_real_pc = '0;
    cyc(2);

    // reset state
    chk("rst_cv", commit_valid, 0);
    chk("rst_rd", commit_rd, 0);
    chk("rst_tag", commit_tag, 0);
    chk("rst_val", commit_val, 0);
    chk("rst_rb", rollback, 0);
    chk("rst_rbpc", rollback_pc, 0);
    chk("rst_full", full, 0);
    chk("rst_alloc", alloc_tag, 1);
    chk("rst_statc", stat_commits, 0);
    rst = 1'b0;

    // 1: basic issue -> CDB -> commit two cycles later, single-cycle pulse
    chk("t1_alloc", alloc_tag, 1);
    do_issue(5, 0, 0);
    chk("t1_alloc2", alloc_tag, 2);
    do_cdb(1, 32'hDEAD, 0);
    chk("t1_early", commit_valid, 0);
    cyc();
    chk("t1_cv", commit_valid, 1);
    chk("t1_rd", commit_rd, 5);
    chk("t1_tag", commit_tag, 1);
    chk("t1_val", commit_val, 32'hDEAD);
    cyc();
    chk("t1_pulse", commit_valid, 0);

    // 2: fill, drop while full (including same-edge commit), issue+commit at 15
    do_rst();
    for (int i = 0; i < 16; i++) do_issue(5'(i + 1), 0, 0);
    chk("t2_full", full, 1);
    chk("t2_alloc", alloc_tag, 1);
    do_issue(9, 0, 0);
    chk("t2_drop_full", full, 1);
    chk("t2_drop_tail", alloc_tag, 1);
    do_cdb(1, 32'h11, 0);
    do_issue(9, 0, 0);
    chk("t2_cv", commit_valid, 1);
    chk("t2_ctag", commit_tag, 1);
    chk("t2_nfull", full, 0);
    chk("t2_rej", alloc_tag, 1);
    do_cdb(2, 32'h22, 0);
    do_issue(7, 0, 0);
    chk("t2_cv2", commit_tag, 2);
    chk("t2_full15", full, 0);
    chk("t2_alloc15", alloc_tag, 2);

    // 3: out-of-order CDB, in-order commit
    do_rst();
    do_issue(1, 0, 0); do_issue(2, 0, 0); do_issue(3, 0, 0);
    do_cdb(3, 32'h33, 0); do_cdb(2, 32'h22, 0); do_cdb(1, 32'h11, 0);
    chk("t3_early", commit_valid, 0);
    cyc();
    chk("t3_c1", {commit_valid, 3'b0, commit_tag, commit_val}, {1'b1, 3'b0, 5'd1, 32'h11});
    cyc();
    chk("t3_c2", {commit_valid, 3'b0, commit_tag, commit_val}, {1'b1, 3'b0, 5'd2, 32'h22});
    cyc();
    chk("t3_c3", {commit_valid, 3'b0, commit_tag, commit_val}, {1'b1, 3'b0, 5'd3, 32'h33});
    chk("t3_rd3", commit_rd, 3);
    cyc();
    chk("t3_end", commit_valid, 0);

    // 4: mispredict rollback, then a correctly predicted branch
    do_rst();
    do_issue(0, 1, 32'h100);
    do_issue(9, 0, 0);
    do_cdb(2, 32'h1, 0);
    do_cdb(1, 32'h0, 32'h200);
    do_issue(4, 0, 0);
    chk("t4_cv", commit_valid, 1);
    chk("t4_crd", commit_rd, 0);
    chk("t4_ctag", commit_tag, 1);
    chk("t4_rb", rollback, 1);
    chk("t4_rbpc", rollback_pc, 32'h200);
    chk("t4_alloc", alloc_tag, 1);
    chk("t4_full", full, 0);
    do_issue(6, 0, 0);
    chk("t4_rb_pulse", rollback, 0);
    chk("t4_flushed", commit_valid, 0);
    chk("t4_ign", alloc_tag, 1);
    chk("t4_statr", stat_rollbacks, STATS ? 1 : 0);
    do_issue(0, 1, 32'h300);
    do_cdb(1, 32'h0, 32'h300);
    cyc();
    chk("t4_okbr_cv", commit_valid, 1);
    chk("t4_okbr_rb", rollback, 0);
    chk("t4_statc", stat_commits, STATS ? 2 : 0);

    // 5: wrap through 40 issue/commit pairs, then a CDB to tag 0
    do_rst();
    for (int i = 0; i < 40; i++) begin
      chk("t5_alloc", alloc_tag, (i % 16) + 1);
      do_issue(5'(i % 31 + 1), 0, 0);
      do_cdb(5'((i % 16) + 1), 32'(i + 32'h1000), 0);
      cyc();
      chk("t5_cv", commit_valid, 1);
      chk("t5_tag", commit_tag, (i % 16) + 1);
      chk("t5_val", commit_val, i + 32'h1000);
    end
    chk("t5_alloc_end", alloc_tag, 9);
    do_issue(2, 0, 0);
    do_cdb(0, 32'hBAD, 0);
    cyc();
    chk("t5_tag0", commit_valid, 0);
    do_cdb(9, 32'h99, 0);
    cyc();
    chk("t5_after0", {commit_valid, 3'b0, commit_tag, commit_val}, {1'b1, 3'b0, 5'd9, 32'h99});

    // 6: rdy low holds a ready head; rdy low also clears commit_valid; rst mid-run
    do_rst();
    do_issue(3, 0, 0);
    do_cdb(1, 32'h77, 0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_hold", commit_valid, 0);
    end
    rdy = 1'b1;
    cyc();
    chk("t6_cv", commit_valid, 1);
    chk("t6_val", commit_val, 32'h77);
    rdy = 1'b0;
    do_issue(4, 0, 0);
    chk("t6_cv_off", commit_valid, 0);
    chk("t6_noiss", alloc_tag, 2);
    rdy = 1'b1;
    do_issue(4, 0, 0);
    do_issue(5, 0, 0);
    do_cdb(2, 32'h5, 0);
    rst = 1'b1;
    cyc();
    chk("t6_rst_cv", commit_valid, 0);
    chk("t6_rst_tag", commit_tag, 0);
    chk("t6_rst_val", commit_val, 0);
    chk("t6_rst_alloc", alloc_tag, 1);
    chk("t6_rst_stat", stat_commits, 0);
    rst = 1'b0;
    cyc(2);
    chk("t6_discard", commit_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
